// File: rtl/idli_pio_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : idli_pio_m                                                    |
// | Purpose  : General-purpose pin I/O unit. Synchronises the input pins,    |
// |            optionally records sticky rising/falling edge flags, holds    |
// |            the output pin latch, and exchanges 16-bit command/status     |
// |            words with the execute stage one 4-bit slice per cycle,       |
// |            aligned to the shared 2-bit slice counter.                    |
// | Macro    : IDLI_PIO_EDGE_EN - when defined, edge flags and the warm-up   |
// |            counter are built; otherwise status bits [11:4] read 0 and    |
// |            write bits [15:8] are ignored.                                |
// | Ports    : i_pio_gck      core clock                                     |
// |            i_pio_rst_n    asynchronous active-low reset                  |
// |            i_pio_ctr      shared slice counter (0..3, every cycle)       |
// |            i_pio_data     write-word slice, LSB slice first              |
// |            i_pio_wr_vld   execute stage streams a write word             |
// |            o_pio_wr_acp   write word accepted (ctr==0 cycle only)        |
// |            i_pio_rd_req   execute stage requests a status word           |
// |            o_pio_data     status-word slice, LSB slice first             |
// |            o_pio_rd_vld   o_pio_data carries a valid status slice        |
// |            i_pio_pins     asynchronous external input pins               |
// |            o_pio_pins     registered output pins                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module idli_pio_m (
  input  logic       i_pio_gck,
  input  logic       i_pio_rst_n,
  input  logic [1:0] i_pio_ctr,
  input  logic [3:0] i_pio_data,
  input  logic       i_pio_wr_vld,
  output logic       o_pio_wr_acp,
  input  logic       i_pio_rd_req,
  output logic [3:0] o_pio_data,
  output logic       o_pio_rd_vld,
  input  logic [3:0] i_pio_pins,
  output logic [3:0] o_pio_pins
);

  typedef enum logic [0:0] {WIDLE = 1'b0, WBUSY = 1'b1} wstate_t;
  typedef enum logic [0:0] {RIDLE = 1'b0, RBUSY = 1'b1} rstate_t;

  wstate_t     wstate;
  wstate_t     wstate_nxt;
  rstate_t     rstate;
  rstate_t     rstate_nxt;

  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [3:0]  out_q;
  logic [7:0]  wbuf;        // [3:0] output value, [7:4] output write mask
  logic [15:0] status;
  logic [15:0] snap;
  logic        wr_slice_en; // a write word is still streaming in WBUSY
  logic        wr_apply;    // final slice present: commit the word this edge
  logic        snap_ld;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      s1 <= 4'h0;
      s2 <= 4'h0;
    end else begin
      s1 <= i_pio_pins;
      s2 <= s1;
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      wstate <= WIDLE;
    end else begin
      wstate <= wstate_nxt;
    end
  end

  always_comb begin
    wstate_nxt   = wstate;
    o_pio_wr_acp = 1'b0;
    wr_apply     = 1'b0;
    wr_slice_en  = 1'b0;
    case (wstate)
      WIDLE: begin
        if ((i_pio_ctr == 2'd0) && i_pio_wr_vld) begin
          o_pio_wr_acp = 1'b1;
          wstate_nxt   = WBUSY;
        end
      end
      WBUSY: begin
        if (!i_pio_wr_vld) begin
          // Word abandoned mid-stream: drop the partial buffer contents.
          wstate_nxt = WIDLE;
        end else begin
          wr_slice_en = 1'b1;
          if (i_pio_ctr == 2'd3) begin
            wr_apply   = 1'b1;
            wstate_nxt = WIDLE;
          end
        end
      end
      default: wstate_nxt = WIDLE;
    endcase
  end

  // Slice buffer and output latch. Slice 3 is never buffered: it is used
  // straight from i_pio_data on the commit edge.
  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      wbuf  <= 8'h00;
      out_q <= 4'h0;
    end else begin
      if (o_pio_wr_acp) begin
        wbuf[3:0] <= i_pio_data;
      end
      if (wr_slice_en && (i_pio_ctr == 2'd1)) begin
        wbuf[7:4] <= i_pio_data;
      end
      if (wr_apply) begin
        out_q <= (out_q & ~wbuf[7:4]) | (wbuf[3:0] & wbuf[7:4]);
      end
    end
  end

  assign o_pio_pins = out_q;

  // --------------------------------------------------------------------------
  // Edge flags
  // --------------------------------------------------------------------------
`ifdef IDLI_PIO_EDGE_EN
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rclr;   // buffered rising-flag clear mask (slice 2)
  logic [1:0] warm;
  logic       edge_en;
  logic [3:0] rise_clr;
  logic [3:0] fall_clr;

  // The synchroniser holds reset zeros for two edges; comparing them against
  // live pins would fake an edge for any pin that is high at reset release.
  assign edge_en  = (warm == 2'd2);
  assign rise_clr = wr_apply ? rclr : 4'h0;
  assign fall_clr = wr_apply ? i_pio_data : 4'h0;

  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      rise <= 4'h0;
      fall <= 4'h0;
      rclr <= 4'h0;
      warm <= 2'd0;
    end else begin
      if (!edge_en) begin
        warm <= warm + 2'd1;
      end
      if (wr_slice_en && (i_pio_ctr == 2'd2)) begin
        rclr <= i_pio_data;
      end
      // Set is ORed in after the clear so an edge arriving on the commit
      // edge survives.
      rise <= (rise & ~rise_clr) | (edge_en ? (s1 & ~s2) : 4'h0);
      fall <= (fall & ~fall_clr) | (edge_en ? (~s1 & s2) : 4'h0);
    end
  end

  assign status = {out_q, fall, rise, s2};
`else
  assign status = {out_q, 8'h00, s2};
`endif

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      rstate <= RIDLE;
    end else begin
      rstate <= rstate_nxt;
    end
  end

  always_comb begin
    rstate_nxt   = rstate;
    o_pio_rd_vld = 1'b0;
    o_pio_data   = 4'h0;
    snap_ld      = 1'b0;
    case (rstate)
      RIDLE: begin
        if ((i_pio_ctr == 2'd0) && i_pio_rd_req) begin
          // Slice 0 comes from live state; the rest from the snapshot so
          // the word is coherent even if a write commits mid-read.
          o_pio_rd_vld = 1'b1;
          o_pio_data   = status[3:0];
          snap_ld      = 1'b1;
          rstate_nxt   = RBUSY;
        end
      end
      RBUSY: begin
        o_pio_rd_vld = 1'b1;
        o_pio_data   = snap[{i_pio_ctr, 2'b00} +: 4];
        if (i_pio_ctr == 2'd3) begin
          rstate_nxt = RIDLE;
        end
      end
      default: rstate_nxt = RIDLE;
    endcase
  end

  always_ff @(posedge i_pio_gck or negedge i_pio_rst_n) begin
    if (!i_pio_rst_n) begin
      snap <= 16'h0000;
    end else if (snap_ld) begin
      snap <= status;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idli_pio_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_idli_pio_m                                                 |
// | Purpose  : Self-checking bench for idli_pio_m. Directed scenarios plus   |
// |            randomised word traffic, compared against a behavioural       |
// |            model of pins, flags and the output latch.                    |
// | Macro    : IDLI_PIO_EDGE_EN selects the expected status layout.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_idli_pio_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ctr = 2'd0;
  logic [3:0] data = 4'h0;
  logic       wr_vld = 1'b0;
  logic       rd_req = 1'b0;
  logic [3:0] pins = 4'h0;
  logic       wr_acp;
  logic [3:0] rdata;
  logic       rd_vld;
  logic [3:0] pins_out;

  int checks = 0;
  int errors = 0;

  idli_pio_m dut (
    .i_pio_gck    (clk),
    .i_pio_rst_n  (rst_n),
    .i_pio_ctr    (ctr),
    .i_pio_data   (data),
    .i_pio_wr_vld (wr_vld),
    .o_pio_wr_acp (wr_acp),
    .i_pio_rd_req (rd_req),
    .o_pio_data   (rdata),
    .o_pio_rd_vld (rd_vld),
    .i_pio_pins   (pins),
    .o_pio_pins   (pins_out)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: the synchronised pin view is the pin value sampled two
  // edges back; flags record changes of that view once warm-up is over; a
  // committed word updates the latch and clears flags, new edges winning.
  // --------------------------------------------------------------------------
  logic [3:0]  pin_hist[$];
  int          m_edges = 0;
  logic [3:0]  m_sync = 4'h0;
  logic [3:0]  m_rise = 4'h0;
  logic [3:0]  m_fall = 4'h0;
  logic [3:0]  m_out = 4'h0;
  bit          ap_pend = 1'b0;
  logic [15:0] ap_word = 16'h0;
  logic [3:0]  nsync;
  logic [3:0]  rises;
  logic [3:0]  falls;

  always @(posedge clk) begin
    if (rst_n) begin
      m_edges = m_edges + 1;
      pin_hist.push_back(pins);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
      nsync = (pin_hist.size() == 2) ? pin_hist[0] : 4'h0;
      rises = (m_edges >= 3) ? (nsync & ~m_sync) : 4'h0;
      falls = (m_edges >= 3) ? (~nsync & m_sync) : 4'h0;
      if (ap_pend) begin
        m_out  = (m_out & ~ap_word[7:4]) | (ap_word[3:0] & ap_word[7:4]);
        m_rise = m_rise & ~ap_word[11:8];
        m_fall = m_fall & ~ap_word[15:12];
        ap_pend = 1'b0;
      end
      m_rise = m_rise | rises;
      m_fall = m_fall | falls;
      m_sync = nsync;
    end
  end

  function automatic logic [15:0] exp_status();
`ifdef IDLI_PIO_EDGE_EN
    return {m_out, m_fall, m_rise, m_sync};
`else
    return {m_out, 8'h00, m_sync};
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ctr = ctr + 2'd1;
  endtask

  // Idle until the counter is back at 0, checking quiet handshakes.
  task automatic align();
    do begin
      @(negedge clk);
      check("idle_acp", 16'(wr_acp), 16'h0);
      check("idle_rdvld", 16'(rd_vld), 16'h0);
      check("idle_pins", 16'(pins_out), 16'(m_out));
      step();
    end while (ctr != 2'd0);
  endtask

  task automatic do_reset(input int cyc);
    wr_vld = 1'b0;
    rd_req = 1'b0;
    data   = 4'h0;
    rst_n  = 1'b0;
    m_out = 4'h0; m_rise = 4'h0; m_fall = 4'h0; m_sync = 4'h0;
    m_edges = 0; ap_pend = 1'b0;
    pin_hist.delete();
    #1;
    check("rst_pins", 16'(pins_out), 16'h0);
    check("rst_data", 16'(rdata), 16'h0);
    check("rst_rdvld", 16'(rd_vld), 16'h0);
    check("rst_acp", 16'(wr_acp), 16'h0);
    repeat (cyc) step();
    rst_n = 1'b1;
  endtask

  // One word period starting at ctr==0 (just after the edge).
  task automatic xfer(input logic [15:0] w, input bit wr, input bit rd,
                      input int drop_at, input int pulse_k, input logic [3:0] pulse_mask,
                      input bit rnd, output logic [15:0] got);
    logic [15:0] exp;
    exp = exp_status();
    got = 16'h0;
    for (int k = 0; k < 4; k++) begin
      wr_vld = wr && (k < drop_at);
      data   = w[k*4 +: 4];
      rd_req = rd && (k == 0);
      if (k == pulse_k || k == pulse_k + 1) pins = pins ^ pulse_mask;
      if (rnd && $urandom_range(0, 2) == 0) pins = 4'($urandom);
      if (wr && drop_at == 4 && k == 3) begin
        ap_pend = 1'b1;
        ap_word = w;
      end
      @(negedge clk);
      check("wr_acp", 16'(wr_acp), 16'(wr && drop_at > 0 && k == 0));
      check("rd_vld", 16'(rd_vld), 16'(rd));
      if (rd) check("rd_data", 16'(rdata), 16'(exp[k*4 +: 4]));
      check("out_pins", 16'(pins_out), 16'(m_out));
      got[k*4 +: 4] = rdata;
      step();
    end
    wr_vld = 1'b0;
    rd_req = 1'b0;
    data   = 4'h0;
    if (pulse_k == 3) pins = pins ^ pulse_mask;
  endtask

  logic [15:0] got;

  initial begin
    #2;
    do_reset(3);
    align();

    // Output latch writes
    xfer(16'h00FA, 1, 0, 4, -1, 4'h0, 0, got);
    @(negedge clk);
    check("pins_A", 16'(pins_out), 16'h000A);
    step(); align();
    xfer(16'h0035, 1, 0, 4, -1, 4'h0, 0, got);
    @(negedge clk);
    check("pins_9", 16'(pins_out), 16'h0009);
    step(); align();

    // Rising edge on pin 0, then clear it
    pins = 4'h1;
    align();
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
    check("p0_sync", 16'(got[3:0]), 16'h0001);
`ifdef IDLI_PIO_EDGE_EN
    check("p0_rise", 16'(got[7:4]), 16'h0001);
`endif
    xfer(16'h0100, 1, 0, 4, -1, 4'h0, 0, got);
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
    check("p0_rise_clr", 16'(got[7:4]), 16'h0000);

    // wr_vld outside ctr==0 in idle is ignored
    step();
    wr_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_acp", 16'(wr_acp), 16'h0);
      step();
    end
    wr_vld = 1'b0;

    // Abandoned write, then a normal one
    xfer(16'h00FF, 1, 0, 2, -1, 4'h0, 0, got);
    @(negedge clk);
    check("drop_keep", 16'(pins_out), 16'h0009);
    step(); align();
    xfer(16'h0030, 1, 1, 4, -1, 4'h0, 0, got);
    @(negedge clk);
    check("after_drop", 16'(pins_out), 16'h0008);
    step(); align();

    // Pins high through reset release raise no flag
    pins = 4'hF;
    do_reset(2);
    align(); align(); align();
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
    check("hot_sync", 16'(got[3:0]), 16'h000F);
    check("hot_flags", 16'(got[11:4]), 16'h0000);

    // Falling edge racing a fall-flag clear
    xfer(16'hF000, 1, 0, 4, 3, 4'h4, 0, got);
    align();
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
`ifdef IDLI_PIO_EDGE_EN
    check("fall2_k3", 16'(got[10]), 16'h0001);
`endif
    xfer(16'hF000, 1, 0, 4, 2, 4'h4, 0, got);
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
`ifdef IDLI_PIO_EDGE_EN
    check("fall2_k2", 16'(got[10]), 16'h0001);
`endif

    // Toggling pins; flags absent in the default build
    pins = 4'h5; align();
    pins = 4'hA; align();
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
`ifndef IDLI_PIO_EDGE_EN
    check("noedge_mid", 16'(got[11:4]), 16'h0000);
`endif

    // Reset in the middle of a write and a read
    xfer(16'h00FA, 1, 0, 4, -1, 4'h0, 0, got);
    wr_vld = 1'b1; rd_req = 1'b1; data = 4'h5;
    step();
    rd_req = 1'b0; data = 4'hF;
    step();
    do_reset(2);
    align();
    xfer(16'h0, 0, 1, 4, -1, 4'h0, 0, got);
    check("mid_rst_out", 16'(got[15:12]), 16'h0000);

    // Randomised traffic with overlapping reads and writes
    for (int i = 0; i < 60; i++) begin
      int   drop;
      logic [15:0] w;
      bit   wr;
      bit   rd;
      w    = 16'($urandom);
      wr   = ($urandom_range(0, 3) != 0);
      rd   = ($urandom_range(0, 2) != 0);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 4;
      xfer(w, wr, rd, drop, -1, 4'h0, 1, got);
      if ($urandom_range(0, 4) == 0) align();
    end
    align();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
